// File: rtl/cwseq_pkg.sv
// Shared types and ControlWord layout for the control word sequencer.
package cwseq_pkg;

    typedef enum logic [1:0] {IDLE, FETCH2, SWAP1, SWAP2} state_t;

    localparam int unsigned CW_W = 55;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU0  = 4'h1;
    localparam logic [3:0] OP_ALU1  = 4'h2;
    localparam logic [3:0] OP_SHIFT = 4'h3;
    localparam logic [3:0] OP_LDI   = 4'h4;
    localparam logic [3:0] OP_ALUI  = 4'h5;
    localparam logic [3:0] OP_SWAP  = 4'h6;

    localparam int unsigned DA_LSB  = 52;
    localparam int unsigned AA_LSB  = 49;
    localparam int unsigned BA_LSB  = 46;
    localparam int unsigned MB_BIT  = 45;
    localparam int unsigned FS_LSB  = 41;
    localparam int unsigned SHT_LSB = 38;
    localparam int unsigned SHA_LSB = 34;
    localparam int unsigned MD_BIT  = 33;
    localparam int unsigned RW_BIT  = 32;
    localparam int unsigned CB_LSB  = 16;
    localparam int unsigned CD_LSB  = 0;

    localparam logic [CW_W-1:0] CW_NOP = '0;

    typedef struct packed {
        logic [2:0]  da;
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic        mb;
        logic [3:0]  fs;
        logic [2:0]  sh_type;
        logic [3:0]  sh_amt;
        logic        md;
        logic        rw;
        logic [15:0] const_b;
        logic [15:0] const_d;
    } cw_fields_t;

endpackage

// File: rtl/cw_pack.sv
// Places individual control fields at their ControlWord bit positions.
module cw_pack
    import cwseq_pkg::*;
(
    input  cw_fields_t       fields,
    output logic [CW_W-1:0]  word
);

    always_comb begin
        word = CW_NOP;
        word[DA_LSB  +: 3]  = fields.da;
        word[AA_LSB  +: 3]  = fields.aa;
        word[BA_LSB  +: 3]  = fields.ba;
        word[MB_BIT]        = fields.mb;
        word[FS_LSB  +: 4]  = fields.fs;
        word[SHT_LSB +: 3]  = fields.sh_type;
        word[SHA_LSB +: 4]  = fields.sh_amt;
        word[MD_BIT]        = fields.md;
        word[RW_BIT]        = fields.rw;
        word[CB_LSB  +: 16] = fields.const_b;
        word[CD_LSB  +: 16] = fields.const_d;
    end

endmodule

// File: rtl/control_word_sequencer.sv
// Decodes 16-bit instructions into 55-bit datapath control words, one per clock.
// Optional illegal-opcode trap enabled by defining CWSEQ_ILLEGAL_TRAP_EN.
module control_word_sequencer
    import cwseq_pkg::*;
#(
    parameter logic [3:0] FS_XOR   = 4'h7,
    parameter logic [3:0] FS_PASSB = 4'hC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [CW_W-1:0]  ControlWord,
    output logic             cw_valid,
    input  logic             Overflow,
    input  logic             CarryOut,
    input  logic             Negative,
    input  logic             Zero,
    output logic [3:0]       flags_q,
    output logic             busy
`ifdef CWSEQ_ILLEGAL_TRAP_EN
    , output logic           illegal
`endif
);

`ifdef CWSEQ_ILLEGAL_TRAP_EN
    localparam bit ILLEGAL_NOP = 1'b0;
`else
    localparam bit ILLEGAL_NOP = 1'b1;
`endif

    logic [3:0]      op;
    logic [2:0]      rd, ra, rb, sub;
    state_t          state;
    logic [2:0]      pend_rd, pend_ra, pend_sub;
    logic            pend_ldi;
    logic            trap;
    logic            accept;
    logic            issue;
    cw_fields_t      fields;
    logic [CW_W-1:0] cw_next;

    assign op  = instr[15:12];
    assign rd  = instr[11:9];
    assign ra  = instr[8:6];
    assign rb  = instr[5:3];
    assign sub = instr[2:0];

`ifdef CWSEQ_ILLEGAL_TRAP_EN
    assign trap = illegal;
`else
    assign trap = 1'b0;
`endif

    assign instr_ready = ((state == IDLE) || (state == FETCH2)) && !trap;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != IDLE);

    // Field selection for the word issued at the next edge
    always_comb begin
        fields = '0;
        issue  = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                case (op)
                    OP_NOP: issue = 1'b1;
                    OP_ALU0, OP_ALU1: begin
                        issue     = 1'b1;
                        fields.da = rd;
                        fields.aa = ra;
                        fields.ba = rb;
                        fields.fs = {op[1], sub};
                        fields.rw = 1'b1;
                    end
                    OP_SHIFT: begin
                        issue          = 1'b1;
                        fields.da      = rd;
                        fields.ba      = instr[8:6];
                        fields.sh_amt  = instr[5:2];
                        fields.sh_type = {1'b0, instr[1:0]};
                        fields.fs      = FS_PASSB;
                        fields.rw      = 1'b1;
                    end
                    OP_LDI, OP_ALUI: issue = 1'b0;
                    OP_SWAP: begin
                        issue     = 1'b1;
                        fields.da = rd;
                        fields.aa = rd;
                        fields.ba = ra;
                        fields.fs = FS_XOR;
                        fields.rw = 1'b1;
                    end
                    default: issue = ILLEGAL_NOP;
                endcase
            end
            FETCH2: if (accept) begin
                issue     = 1'b1;
                fields.da = pend_rd;
                fields.rw = 1'b1;
                if (pend_ldi) begin
                    fields.md      = 1'b1;
                    fields.const_d = instr;
                end else begin
                    fields.aa      = pend_ra;
                    fields.mb      = 1'b1;
                    fields.const_b = instr;
                    fields.fs      = {1'b0, pend_sub};
                end
            end
            SWAP1: begin
                issue     = 1'b1;
                fields.da = pend_ra;
                fields.aa = pend_rd;
                fields.ba = pend_ra;
                fields.fs = FS_XOR;
                fields.rw = 1'b1;
            end
            SWAP2: begin
                issue     = 1'b1;
                fields.da = pend_rd;
                fields.aa = pend_rd;
                fields.ba = pend_ra;
                fields.fs = FS_XOR;
                fields.rw = 1'b1;
            end
        endcase
    end

    cw_pack u_cw_pack (
        .fields (fields),
        .word   (cw_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ControlWord <= CW_NOP;
            cw_valid    <= 1'b0;
            flags_q     <= 4'b0000;
            pend_rd     <= 3'd0;
            pend_ra     <= 3'd0;
            pend_sub    <= 3'd0;
            pend_ldi    <= 1'b0;
`ifdef CWSEQ_ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            ControlWord <= issue ? cw_next : CW_NOP;
            cw_valid    <= issue;
            // Flags belong to the word currently on ControlWord
            if (ControlWord[RW_BIT] && !ControlWord[MD_BIT])
                flags_q <= {Overflow, CarryOut, Negative, Zero};
            unique case (state)
                IDLE: if (accept) begin
                    pend_rd  <= rd;
                    pend_ra  <= ra;
                    pend_sub <= sub;
                    pend_ldi <= (op == OP_LDI);
                    if ((op == OP_LDI) || (op == OP_ALUI))
                        state <= FETCH2;
                    else if (op == OP_SWAP)
                        state <= SWAP1;
`ifdef CWSEQ_ILLEGAL_TRAP_EN
                    if (op > OP_SWAP)
                        illegal <= 1'b1;
`endif
                end
                FETCH2: if (accept) state <= IDLE;
                SWAP1: state <= SWAP2;
                SWAP2: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_word_sequencer.sv
// Self-checking bench for control_word_sequencer: directed steps plus random traffic
// compared against an instruction-level reference model.
module tb_control_word_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [54:0] ControlWord;
    logic        cw_valid;
    logic        Overflow, CarryOut, Negative, Zero;
    logic [3:0]  flags_q;
    logic        busy;
`ifdef CWSEQ_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    int n_pass  = 0;
    int n_total = 0;

    control_word_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ControlWord (ControlWord),
        .cw_valid    (cw_valid),
        .Overflow    (Overflow),
        .CarryOut    (CarryOut),
        .Negative    (Negative),
        .Zero        (Zero),
        .flags_q     (flags_q),
        .busy        (busy)
`ifdef CWSEQ_ILLEGAL_TRAP_EN
        , .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: words still owed, pending second word, trap
    logic [54:0] m_sched[$];
    logic [54:0] m_cur;
    logic [3:0]  m_flags;
    bit          m_want2, m_ldi, m_trap;
    int          m_rd, m_ra, m_sub;

    function automatic logic [54:0] mk(input int da, aa, ba, mb, fs, sht, sha, md, rw, cb, cd);
        return {3'(da), 3'(aa), 3'(ba), 1'(mb), 4'(fs), 3'(sht), 4'(sha),
                1'(md), 1'(rw), 16'(cb), 16'(cd)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_sched.delete();
        m_cur   = '0;
        m_flags = 4'b0000;
        m_want2 = 1'b0;
        m_ldi   = 1'b0;
        m_trap  = 1'b0;
    endtask

    // One clock: check ready, apply inputs at negedge, predict, check outputs at next negedge
    task automatic step(input logic v, input logic [15:0] w, input logic [3:0] fl);
        bit          rdy;
        logic [54:0] exp_cw;
        bit          exp_v;
        int          op, rd, ra, rb, sb;
        rdy = (m_sched.size() == 0) && !m_trap;
        chk("instr_ready", 64'(instr_ready), 64'(rdy));
        exp_cw = '0;
        exp_v  = 1'b0;
        op = int'(w[15:12]); rd = int'(w[11:9]); ra = int'(w[8:6]);
        rb = int'(w[5:3]);   sb = int'(w[2:0]);
        if (m_sched.size() > 0) begin
            exp_cw = m_sched.pop_front();
            exp_v  = 1'b1;
        end else if (v && rdy) begin
            if (m_want2) begin
                m_want2 = 1'b0;
                exp_v   = 1'b1;
                exp_cw  = m_ldi ? mk(m_rd, 0, 0, 0, 0, 0, 0, 1, 1, 0, int'(w))
                                : mk(m_rd, m_ra, 0, 1, m_sub, 0, 0, 0, 1, int'(w), 0);
            end else begin
                case (op)
                    0: exp_v = 1'b1;
                    1: begin exp_v = 1'b1; exp_cw = mk(rd, ra, rb, 0, sb, 0, 0, 0, 1, 0, 0); end
                    2: begin exp_v = 1'b1; exp_cw = mk(rd, ra, rb, 0, 8 + sb, 0, 0, 0, 1, 0, 0); end
                    3: begin
                        exp_v  = 1'b1;
                        exp_cw = mk(rd, 0, int'(w[8:6]), 0, 12, int'(w[1:0]), int'(w[5:2]), 0, 1, 0, 0);
                    end
                    4, 5: begin
                        m_want2 = 1'b1; m_ldi = (op == 4);
                        m_rd = rd; m_ra = ra; m_sub = sb;
                    end
                    6: begin
                        exp_v  = 1'b1;
                        exp_cw = mk(rd, rd, ra, 0, 7, 0, 0, 0, 1, 0, 0);
                        m_sched.push_back(mk(ra, rd, ra, 0, 7, 0, 0, 0, 1, 0, 0));
                        m_sched.push_back(mk(rd, rd, ra, 0, 7, 0, 0, 0, 1, 0, 0));
                    end
                    default: begin
`ifdef CWSEQ_ILLEGAL_TRAP_EN
                        m_trap = 1'b1;
`else
                        exp_v = 1'b1;
`endif
                    end
                endcase
            end
        end
        if (m_cur[32] && !m_cur[33]) m_flags = fl;
        m_cur = exp_cw;
        instr_valid = v;
        instr       = w;
        {Overflow, CarryOut, Negative, Zero} = fl;
        @(posedge clk);
        @(negedge clk);
        chk("ControlWord", 64'(ControlWord), 64'(exp_cw));
        chk("cw_valid", 64'(cw_valid), 64'(exp_v));
        chk("flags_q", 64'(flags_q), 64'(m_flags));
        chk("busy", 64'(busy), 64'(m_want2 || (m_sched.size() > 0)));
`ifdef CWSEQ_ILLEGAL_TRAP_EN
        chk("illegal", 64'(illegal), 64'(m_trap));
`endif
    endtask

    // Asynchronous reset pulse applied between edges
    task automatic do_reset();
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_cw", 64'(ControlWord), 64'd0);
        chk("rst_cw_valid", 64'(cw_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'(flags_q), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [54:0] alu_exp;
        int          da_seq[3];
        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        {Overflow, CarryOut, Negative, Zero} = 4'b0000;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // ALU rd=5 ra=1 rb=2 sub=1
        step(1'b1, 16'h1A51, 4'b0000);
        alu_exp = {3'd5, 3'd1, 3'd2, 1'b0, 4'd1, 3'd0, 4'd0, 1'b0, 1'b1, 16'd0, 16'd0};
        chk("alu_word", 64'(ControlWord), 64'(alu_exp));

        // Flags from ALU word (Zero only), then LDI with a 3-cycle gap
        step(1'b1, 16'h4600, 4'b0001);
        chk("flags_zero", 64'(flags_q), 64'b0001);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h1234, 4'b1110);
        chk("ldi_wait_busy", 64'(busy), 64'd1);
        step(1'b1, 16'hBEEF, 4'b1111);
        chk("ldi_constd", 64'(ControlWord[15:0]), 64'hBEEF);
        chk("ldi_busy_low", 64'(busy), 64'd0);
        step(1'b0, 16'h0000, 4'b1010);
        chk("flags_hold", 64'(flags_q), 64'b0001);

        // SWAP rd=2 ra=1: DA sequence 2,1,2 with XOR function
        step(1'b1, 16'h6440, 4'b0000);
        da_seq[0] = int'(ControlWord[54:52]);
        chk("swap_fs", 64'(ControlWord[44:41]), 64'h7);
        step(1'b1, 16'h1A51, 4'b0000);
        da_seq[1] = int'(ControlWord[54:52]);
        step(1'b1, 16'h1A51, 4'b0000);
        da_seq[2] = int'(ControlWord[54:52]);
        chk("swap_da0", 64'(da_seq[0]), 64'd2);
        chk("swap_da1", 64'(da_seq[1]), 64'd1);
        chk("swap_da2", 64'(da_seq[2]), 64'd2);
        step(1'b0, 16'h0000, 4'b0000);

        // Reset while waiting for the ALUI immediate
        step(1'b1, 16'h5000, 4'b0000);
        do_reset();
        step(1'b1, 16'h1A51, 4'b0000);
        chk("post_rst_alu", 64'(ControlWord), 64'(alu_exp));

        // Illegal opcode
        step(1'b1, 16'h9000, 4'b0000);
        step(1'b1, 16'h0000, 4'b0000);
        do_reset();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            logic        v;
            w = 16'($urandom);
`ifdef CWSEQ_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 9) != 0) w[15:12] = 4'($urandom_range(0, 6));
`else
            if ($urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(0, 6));
`endif
            v = ($urandom_range(0, 3) != 0);
            step(v, w, 4'($urandom));
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
